// File: rtl/enc_onehot2bin.sv
// Registered one-hot to binary encoder with a valid/ready handshake.
// Define ENC_ONEHOT2BIN_PRIORITY_EN to make multi-hot inputs return the lowest set index.
module enc_onehot2bin #(
  parameter int WIDTH = 15,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             accept;
  logic             zero_hot;
  logic             multi_hot;
  logic             enc_err;
  logic [OUT_W-1:0] enc_idx;
  logic [CNT_W-1:0] cnt_nxt;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign zero_hot  = ~|in;
  assign multi_hot = |(in & (in - WIDTH'(1)));
  assign enc_err   = zero_hot || multi_hot;

`ifdef ENC_ONEHOT2BIN_PRIORITY_EN
  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    enc_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) enc_idx = OUT_W'(i);
    end
  end
`else
  // Plain OR-tree: each set bit contributes its index.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) enc_idx = enc_idx | OUT_W'(i);
    end
  end
`endif

  // Clear applies first, then an accepted error is counted, saturating.
  always_comb begin
    cnt_nxt = err_clr ? '0 : err_cnt;
    if (accept && enc_err && cnt_nxt != CNT_MAX) begin
      cnt_nxt = cnt_nxt + CNT_W'(1);
    end
  end

  // Output register: load on accept, drop valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out       <= enc_idx;
      out_err   <= enc_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Malformed-input counter for status readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= cnt_nxt;
    end
  end

endmodule

// File: doc/enc_onehot2bin.md
Name: enc_onehot2bin

Overview:
- Registered one-hot to binary encoder, the inverse of the team's binary-to-one-hot decode path.
- Accepts a WIDTH-bit one-hot vector over a valid/ready handshake and returns its binary index one cycle later.
- Flags any input that is not exactly one-hot (zero bits set, or more than one bit set).
- Keeps a saturating count of malformed inputs for debug and status readout.

Parameters:
- WIDTH, 15, width of the one-hot input; legal indices are 0..WIDTH-1.
- OUT_W, 4, width of the binary output; must satisfy 2**OUT_W >= WIDTH.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an input vector is presented.
- in_ready  output  1  block can accept the input this cycle.
- in  input  WIDTH  one-hot vector.
- out_valid  output  1  the output register holds a result.
- out_ready  input  1  the consumer accepts the result.
- out  output  OUT_W  binary index.
- out_err  output  1  the result came from a non-one-hot input.
- err_clr  input  1  synchronously clears err_cnt.
- err_cnt  output  CNT_W  saturating count of accepted malformed inputs.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out=0, out_err=0, err_cnt=0. in_ready is 1 in the first cycle after reset.
- Reset mid-transfer discards any held result. No partial state survives.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one transfer per cycle.
- Accept occurs when in_valid && in_ready. On accept, the next clock loads out, out_err and sets out_valid=1.
- Latency is exactly 1 cycle from accept to out_valid.
- When out_valid && !out_ready, out and out_err hold stable and in_ready=0. The input is not consumed.
- out_valid falls to 0 when out_ready=1 and no accept occurs in the same cycle.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the register reloads with the new result and out_valid stays 1.
- in_valid=0: no register update occurs and the in value is ignored (don't-care).
- Exactly one bit set at index k: out=k, out_err=0.
- Zero bits set: out=0, out_err=1.
- More than one bit set: out_err=1; the out value depends on the optional feature below.
- err_cnt increments by 1 on each accepted transfer with out_err=1 and saturates at 2**CNT_W-1 without wrapping.
- err_clr together with an accepted error in the same cycle: err_cnt=1 (the clear is applied first, then the new error is counted).
- err_clr with no accepted error: err_cnt=0.
- err_cnt updates on the accept edge, coincident with the out_err load.
- Upper bits of out beyond the WIDTH range are never produced for legal inputs. Indices WIDTH..2**OUT_W-1 do not occur.

Optional Feature:
- Macro: ENC_ONEHOT2BIN_PRIORITY_EN.
- Defined: for a multi-hot input, out is the lowest set bit index (priority encode); out_err is still 1.
- Not defined: for a multi-hot input, out is the bitwise OR of the indices of all set bits (plain OR-tree encoder); out_err is 1.
- The one-hot and zero-input results are identical with or without the macro.

Test Plan:
- Reset then sweep: rst for 2 cycles, then in=1<<k for k=0..14 back-to-back with out_ready=1 -> out=k exactly one cycle after each accept, out_err=0, err_cnt=0, no bubbles.
- Zero input: in=15'h0000 accepted -> out=0, out_err=1, err_cnt=1.
- Multi-hot: in=15'h0006 (bits 1 and 2) -> out_err=1; out=1 with the macro defined, out=3 without it; err_cnt increments by 1.
- Backpressure: in=15'h0100 accepted, out_ready=0 for 3 cycles while in_valid=1 with in=15'h0008 -> out holds 8, in_ready=0; after out_ready=1, next output is 3; no input lost or duplicated.
- Saturation and clear: 260 accepted in=0 transfers -> err_cnt stops at 255. err_clr alone -> 0. err_clr coincident with an accepted in=0 -> 1.
- Reset mid-operation: out_valid=1 holding out=5 with out_ready=0, assert rst -> next cycle out_valid=0, out=0, out_err=0, err_cnt=0, in_ready=1.
